n_cobs_trace_arbiter: RTL and testbench

Priority arbiter and sequencer that shares one `n_cobs_encoder` between `NumLevels` trace requesters. It accepts word streams from each requester and drives the encoder's `csr_enable`/`rs1_data`/`level`/`csr_addr`/`timer` inputs. Higher-priority messages may preempt lower ones at word boundaries, producing nested N-COBS frames. It sits between the trace sources and `n_cobs_encoder`, which feeds `fifo_interleaved` and then `uart`.

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/n_cobs_trace_arbiter_prio_pick.sv | 37 +++
 rtl/n_cobs_trace_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_n_cobs_trace_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types and defaults for the N-COBS trace arbiter
//                slice: data word type, default requester count, default
//                encoder CSR address and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // One trace word as presented by a requester and consumed by the encoder
    typedef logic [31:0] word;

    // Default number of trace requesters (index 0 = highest priority)
    localparam int c_NUM_LEVELS = 2;

    // Default CSR address of the N-COBS encoder write port
    localparam logic [11:0] c_CSR_ADDR = 12'h051;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CLOSE  = 2'd2
    } arb_state_e;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/n_cobs_trace_arbiter_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module      : n_cobs_trace_arbiter_prio_pick
//  Description : Combinational lowest-index-set finder over the request
//                vector. An optional lock forces the result to a given
//                index so an in-progress message cannot be preempted.
//  Revision    : 1.0 - initial release
// ============================================================================
module n_cobs_trace_arbiter_prio_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_lock_en,
    input  logic [IDX_W-1:0]   i_lock_idx,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    // Scan from the top down so the lowest set index is the one that sticks
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
        if (i_lock_en) begin
            o_found = 1'b1;
            o_idx   = i_lock_idx;
        end
    end

endmodule : n_cobs_trace_arbiter_prio_pick
`default_nettype wire

// File: rtl/n_cobs_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : n_cobs_trace_arbiter
//  Description : Priority arbiter / sequencer sharing one n_cobs_encoder
//                between NumLevels trace requesters. Words are accepted one
//                per cycle from the granted requester and forwarded to the
//                encoder one cycle later; every completed message is followed
//                by a single CLOSE cycle. Higher-priority requesters may
//                preempt at word boundaries, producing nested frames.
//  Config      : N_COBS_ARB_PREEMPT_EN - when defined, the grant may move to
//                a higher-priority requester on any streaming cycle; when
//                undefined, an in-progress message holds the grant until its
//                last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module n_cobs_trace_arbiter
    import decoder_pkg::*;
#(
    parameter int          NumLevels = c_NUM_LEVELS,
    parameter logic [11:0] CsrAddr   = c_CSR_ADDR,
    parameter int          LevelW    = $clog2(NumLevels + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NumLevels-1:0]       req_valid_i,
    input  logic [NumLevels-1:0][31:0] req_data_i,
    input  logic [NumLevels-1:0]       req_last_i,
    output logic [NumLevels-1:0]       req_ready_o,
    input  logic                       fifo_full_i,
    output logic                       csr_enable_o,
    output logic [31:0]                rs1_data_o,
    output logic [LevelW-1:0]          level_o,
    output logic [11:0]                csr_addr_o,
    output logic [31:0]                timer_o,
    output logic                       busy_o
);

`ifdef N_COBS_ARB_PREEMPT_EN
    localparam logic c_LOCK_EN = 1'b0;
`else
    localparam logic c_LOCK_EN = 1'b1;
`endif

    localparam logic [LevelW-1:0] c_IDLE_LEVEL = LevelW'(NumLevels);

    // Sequencing state
    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [LevelW-1:0]      r_gnt;
    logic [LevelW-1:0]      w_gnt_nxt;
    logic [NumLevels-1:0]   r_inprog;
    logic [NumLevels-1:0]   w_inprog_nxt;

    // Encoder-facing registers
    logic                   r_csr_enable;
    word                    r_rs1_data;
    logic [LevelW-1:0]      r_level;
    word                    r_timer;

    // Acceptance path
    logic [NumLevels-1:0]   w_ready;
    logic                   w_accept;
    logic                   w_acc_last;
    word                    w_acc_data;
    logic                   w_gnt_inprog;

    // Candidate selection
    logic [NumLevels-1:0]   w_cand_vec;
    logic                   w_cand_found;
    logic [LevelW-1:0]      w_cand_idx;
    logic                   w_lock;

    // A stalled in-progress message stays a candidate, so it blocks every
    // lower level while still letting higher levels in
    assign w_cand_vec = req_valid_i | r_inprog;
    assign w_lock     = c_LOCK_EN & w_gnt_inprog;

    n_cobs_trace_arbiter_prio_pick #(
        .NUM_REQ (NumLevels),
        .IDX_W   (LevelW)
    ) u_prio_pick (
        .i_req      (w_cand_vec),
        .i_lock_en  (w_lock),
        .i_lock_idx (r_gnt),
        .o_found    (w_cand_found),
        .o_idx      (w_cand_idx)
    );

    // Select the granted requester's word and raise its ready when streaming
    always_comb begin
        w_ready      = '0;
        w_acc_data   = '0;
        w_acc_last   = 1'b0;
        w_gnt_inprog = 1'b0;
        for (int i = 0; i < NumLevels; i++) begin
            if (r_gnt == LevelW'(i)) begin
                w_ready[i]   = req_valid_i[i] & ~fifo_full_i & (r_state == S_STREAM);
                w_acc_data   = req_data_i[i];
                w_acc_last   = req_last_i[i];
                w_gnt_inprog = r_inprog[i];
            end
        end
        w_accept = |w_ready;
    end

    // Track which requesters have a partially sent message
    always_comb begin
        w_inprog_nxt = r_inprog;
        for (int i = 0; i < NumLevels; i++) begin
            if (w_ready[i]) begin
                w_inprog_nxt[i] = ~req_last_i[i];
            end
        end
    end

    // Next-state and grant decision
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (w_cand_found) begin
                    w_state_nxt = S_STREAM;
                    w_gnt_nxt   = w_cand_idx;
                end
            end
            S_STREAM: begin
                if (w_cand_found) begin
                    w_gnt_nxt = w_cand_idx;
                end
                if (w_accept && w_acc_last) begin
                    w_state_nxt = S_CLOSE;
                end else if (!w_cand_found) begin
                    // Only reachable if a requester withdraws an unaccepted word
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLOSE: begin
                if ((|r_inprog) || (|req_valid_i)) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, grant and in-progress registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_inprog <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_inprog <= w_inprog_nxt;
        end
    end

    // Encoder strobe, data and level; level parks at the idle value once the
    // sequencer has settled in S_IDLE after a CLOSE cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_csr_enable <= 1'b0;
            r_rs1_data   <= '0;
            r_level      <= c_IDLE_LEVEL;
        end else begin
            r_csr_enable <= w_accept;
            if (w_accept) begin
                r_rs1_data <= w_acc_data;
                r_level    <= r_gnt;
            end else if (r_state == S_IDLE) begin
                r_level    <= c_IDLE_LEVEL;
            end
        end
    end

    // Free-running timestamp, wraps naturally at 2^32
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign req_ready_o  = w_ready;
    assign csr_enable_o = r_csr_enable;
    assign rs1_data_o   = r_rs1_data;
    assign level_o      = r_level;
    assign csr_addr_o   = CsrAddr;
    assign timer_o      = r_timer;
    assign busy_o       = |r_inprog;

endmodule : n_cobs_trace_arbiter
`default_nettype wire

// File: tb/tb_n_cobs_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n_cobs_trace_arbiter
//  Description : Self-checking bench for n_cobs_trace_arbiter. Expected
//                encoder words (level + data) are queued as stimulus is
//                planned and compared in order whenever csr_enable_o fires.
//                Honours N_COBS_ARB_PREEMPT_EN for the expected word order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n_cobs_trace_arbiter;
    import decoder_pkg::*;

    localparam int c_NL = 2;
    localparam int c_LW = 2;

    logic                  clk = 1'b0;
    logic                  reset_ni = 1'b0;
    logic [c_NL-1:0]       req_valid_i;
    logic [c_NL-1:0][31:0] req_data_i;
    logic [c_NL-1:0]       req_last_i;
    logic [c_NL-1:0]       req_ready_o;
    logic                  fifo_full_i;
    logic                  csr_enable_o;
    logic [31:0]           rs1_data_o;
    logic [c_LW-1:0]       level_o;
    logic [11:0]           csr_addr_o;
    logic [31:0]           timer_o;
    logic                  busy_o;

    logic drv_valid [c_NL];
    word  drv_data  [c_NL];
    logic drv_last  [c_NL];

    assign req_valid_i = {drv_valid[1], drv_valid[0]};
    assign req_data_i  = {drv_data[1], drv_data[0]};
    assign req_last_i  = {drv_last[1], drv_last[0]};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];
    int unsigned cyc_since_rst;
    bit          l0_done;
    int          viol;

    n_cobs_trace_arbiter u_dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .fifo_full_i  (fifo_full_i),
        .csr_enable_o (csr_enable_o),
        .rs1_data_o   (rs1_data_o),
        .level_o      (level_o),
        .csr_addr_o   (csr_addr_o),
        .timer_o      (timer_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the expected timestamp at each negedge
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) cyc_since_rst <= 0;
        else           cyc_since_rst <= cyc_since_rst + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int lvl, input word d);
        exp_q.push_back({30'd0, c_LW'(lvl), d});
    endtask

    // Present one word and hold it until the arbiter takes it
    task automatic send_word(input int lvl, input word d, input logic last);
        bit got = 1'b0;
        drv_valid[lvl] = 1'b1;
        drv_data[lvl]  = d;
        drv_last[lvl]  = last;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready_o[lvl]) got = 1'b1;
        end
        check("accept_timeout", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
        drv_valid[lvl] = 1'b0;
        drv_last[lvl]  = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every encoder write must match the next planned word
    always @(negedge clk) begin
        if (reset_ni && csr_enable_o) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                check("sb_word", {30'd0, level_o, rs1_data_o}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < c_NL; i++) begin
            drv_valid[i] = 1'b0;
            drv_data[i]  = '0;
            drv_last[i]  = 1'b0;
        end
        fifo_full_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en",    {63'd0, csr_enable_o}, 64'd0);
        check("rst_data",  64'(rs1_data_o), 64'd0);
        check("rst_level", 64'(level_o), 64'd2);
        check("rst_timer", 64'(timer_o), 64'd0);
        check("rst_busy",  {63'd0, busy_o}, 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("csr_addr",  64'(csr_addr_o), 64'h51);
        @(posedge clk);
        #1 reset_ni = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("timer_count", 64'(timer_o), 64'd5);

        // Two-word message on level 1, then CLOSE gap, then idle level
        push_exp(1, 32'h13);
        push_exp(1, 32'h37);
        send_word(1, 32'h13, 1'b0);
        send_word(1, 32'h37, 1'b1);
        @(negedge clk);
        check("busy_after_last", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        check("close_en",    {63'd0, csr_enable_o}, 64'd0);
        check("close_level", 64'(level_o), 64'd1);
        @(negedge clk);
        check("idle_level",  64'(level_o), 64'd2);
        wait_drain();

        // Level 0 arrives while level 1 is mid-message
        push_exp(1, 32'h101);
`ifdef N_COBS_ARB_PREEMPT_EN
        push_exp(0, 32'hDE);
        push_exp(1, 32'h102);
        push_exp(1, 32'h103);
`else
        push_exp(1, 32'h102);
        push_exp(1, 32'h103);
        push_exp(0, 32'hDE);
`endif
        send_word(1, 32'h101, 1'b0);
        fork
            send_word(0, 32'hDE, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_word(1, 32'h102, 1'b0);
                send_word(1, 32'h103, 1'b1);
            end
        join
        wait_drain();

        // Backpressure for 4 cycles during a 4-word message
        for (int k = 0; k < 4; k++) push_exp(1, 32'hB0 + k);
        fork
            begin
                for (int k = 0; k < 4; k++) send_word(1, 32'hB0 + k, (k == 3));
            end
            begin
                @(posedge clk);
                #1 fifo_full_i = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("full_ready", 64'(req_ready_o), 64'd0);
                    if (k > 0) check("full_en", {63'd0, csr_enable_o}, 64'd0);
                end
                @(posedge clk);
                #1 fifo_full_i = 1'b0;
                @(negedge clk);
                check("full_en_last", {63'd0, csr_enable_o}, 64'd0);
            end
        join
        wait_drain();

        // Simultaneous requests from idle: level 0 first, level 1 waits
        repeat (4) @(posedge clk);
        #1;
        push_exp(0, 32'hA0);
        push_exp(0, 32'hA1);
        push_exp(1, 32'hC0);
        l0_done = 1'b0;
        viol    = 0;
        fork
            begin
                send_word(0, 32'hA0, 1'b0);
                send_word(0, 32'hA1, 1'b1);
                l0_done = 1'b1;
            end
            send_word(1, 32'hC0, 1'b1);
            begin
                while (!l0_done) begin
                    @(negedge clk);
                    if (req_ready_o[1]) viol++;
                end
                check("l1_wait", 64'(viol), 64'd0);
            end
        join
        wait_drain();

        // Reset mid-message with the timestamp at 0xFF
        @(negedge clk);
        reset_ni = 1'b0;
        @(posedge clk);
        #1 reset_ni = 1'b1;
        push_exp(1, 32'h55);
        send_word(1, 32'h55, 1'b0);
        @(negedge clk);
        check("busy_mid", {63'd0, busy_o}, 64'd1);
        for (int g = 0; g < 1000 && cyc_since_rst != 255; g++) @(negedge clk);
        check("timer_ff", 64'(timer_o), 64'hFF);
        check("drain_before_rst", 64'(exp_q.size()), 64'd0);
        reset_ni = 1'b0;
        #1;
        check("mid_rst_timer", 64'(timer_o), 64'd0);
        check("mid_rst_en",    {63'd0, csr_enable_o}, 64'd0);
        check("mid_rst_level", 64'(level_o), 64'd2);
        check("mid_rst_busy",  {63'd0, busy_o}, 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #1 reset_ni = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_n_cobs_trace_arbiter
`default_nettype wire
